// File: rtl/phase_pkg.sv
// Shared constants and types for the phase-measurement path.
// Sample width here must match the downstream minimum selector.
package phase_pkg;

    localparam int PHASE_DW  = 13;
    localparam int WIN_CNT_W = 16;

    typedef enum logic [1:0] {
        F0,
        F1,
        F2,
        FULL
    } fill_t;

endpackage

// File: rtl/phase_window3.sv
// Sliding three-sample window over a framed phase stream.
// Window is re-primed at each frame start; valid/ready on both sides.
module phase_window3
    import phase_pkg::*;
#(
    parameter int DW    = PHASE_DW,
    parameter int CNT_W = WIN_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    input  logic             s_sof,
    output logic             s_ready,
    output logic [DW-1:0]    m_a,
    output logic [DW-1:0]    m_b,
    output logic [DW-1:0]    m_c,
    output logic             m_valid,
    output logic             m_sof,
    input  logic             m_ready,
    output logic [CNT_W-1:0] win_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fill_t         fill;
    fill_t         fill_nxt;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    logic          accept;
    logic          handoff;

    // A full pending window blocks input unless it leaves this cycle.
    assign s_ready = (fill != FULL) || !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign handoff = m_valid && m_ready;

    assign m_a = w0;
    assign m_b = w1;
    assign m_c = w2;

    // Fill level: sof restarts at one sample, otherwise count up to FULL.
    always_comb begin
        fill_nxt = fill;
        if (accept) begin
            if (s_sof) begin
                fill_nxt = F1;
            end else begin
                unique case (fill)
                    F0:   fill_nxt = F1;
                    F1:   fill_nxt = F2;
                    F2:   fill_nxt = FULL;
                    FULL: fill_nxt = FULL;
                endcase
            end
        end
    end

    // Fill state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= F0;
        end else begin
            fill <= fill_nxt;
        end
    end

    // Window shift; an sof sample only loads the newest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0 <= '0;
            w1 <= '0;
            w2 <= '0;
        end else if (accept) begin
            if (!s_sof) begin
                w0 <= w1;
                w1 <= w2;
            end
            w2 <= s_data;
        end
    end

    // Output flags: set by an accept that fills the window, held until moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
        end else if (accept) begin
            m_valid <= (fill_nxt == FULL);
            m_sof   <= (fill == F2) && !s_sof;
        end else if (handoff) begin
            m_valid <= 1'b0;
        end
    end

    // Windows delivered in this frame; sof wins over a same-cycle hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (accept && s_sof) begin
            win_cnt <= '0;
        end else if (handoff && win_cnt != CNT_MAX) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_window3.sv
// Randomized and directed bench for phase_window3.
// Reference model keeps the frame's recent samples in a queue.
module tb_phase_window3;
    import phase_pkg::*;

    localparam int DW = PHASE_DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          m_ready = 1'b0;

    logic          s_ready, m_valid, m_sof;
    logic [DW-1:0] m_a, m_b, m_c;
    logic [15:0]   win_cnt;

    logic          s_ready2, m_valid2, m_sof2;
    logic [DW-1:0] m_a2, m_b2, m_c2;
    logic [1:0]    win_cnt2;

    always #5 clk = ~clk;

    phase_window3 dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready),
        .m_a(m_a), .m_b(m_b), .m_c(m_c),
        .m_valid(m_valid), .m_sof(m_sof), .m_ready(m_ready),
        .win_cnt(win_cnt)
    );

    phase_window3 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready2),
        .m_a(m_a2), .m_b(m_b2), .m_c(m_c2),
        .m_valid(m_valid2), .m_sof(m_sof2), .m_ready(m_ready),
        .win_cnt(win_cnt2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state.
    int q[$];
    int frame_n;
    bit pend;
    bit msof;
    int wa, wb, wc;
    int cnt, cnt2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        frame_n = 0;
        pend = 0;
        msof = 0;
        cnt = 0;
        cnt2 = 0;
    endtask

    task automatic check_outputs();
        chk("m_valid", m_valid, pend);
        chk("m_sof", m_sof, msof);
        chk("win_cnt", win_cnt, cnt);
        chk("m_valid2", m_valid2, pend);
        chk("m_sof2", m_sof2, msof);
        chk("win_cnt2", win_cnt2, cnt2);
        if (pend) begin
            chk("m_a", m_a, wa);
            chk("m_b", m_b, wb);
            chk("m_c", m_c, wc);
            chk("m_a2", m_a2, wa);
            chk("m_b2", m_b2, wb);
            chk("m_c2", m_c2, wc);
        end
    endtask

    task automatic step(input bit v, input bit sof, input int d,
                        input bit rdy);
        bit acc, ho, er;
        int dm;
        dm = d & ((1 << DW) - 1);
        @(negedge clk);
        s_valid = v;
        s_sof   = sof;
        s_data  = dm[DW-1:0];
        m_ready = rdy;
        #1;
        er = !pend || rdy;
        chk("s_ready", s_ready, er);
        chk("s_ready2", s_ready2, er);
        acc = v && er;
        ho  = pend && rdy;
        @(posedge clk);
        if (ho) begin
            if (cnt < 65535) cnt++;
            if (cnt2 < 3) cnt2++;
        end
        if (acc) begin
            if (sof) begin
                q.delete();
                frame_n = 0;
                cnt = 0;
                cnt2 = 0;
            end
            q.push_back(dm);
            frame_n++;
            if (q.size() > 3) void'(q.pop_front());
            if (q.size() == 3) begin
                pend = 1;
                msof = (frame_n == 3);
                wa = q[0];
                wb = q[1];
                wc = q[2];
            end else begin
                pend = 0;
                msof = 0;
            end
        end else if (ho) begin
            pend = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        s_valid = 0;
        m_ready = 0;
        #2;
        rst_n = 0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_abc", {m_a, m_b, m_c}, 0);
        chk("rst_win_cnt", win_cnt, 0);
        chk("rst_s_ready", s_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_abc", {m_a, m_b, m_c}, 0);
        chk("reset_win_cnt", win_cnt, 0);
        chk("reset_s_ready", s_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // Prime and stream.
        step(1, 1, 100, 1);
        step(1, 0, 200, 1);
        step(1, 0, 300, 1);
        chk("prime_m_sof", m_sof, 1);
        chk("prime_m_a", m_a, 100);
        step(1, 0, 400, 1);
        step(1, 0, 500, 1);
        step(0, 0, 0, 1);
        chk("stream_cnt", win_cnt, 3);

        // Backpressure with a pending window.
        step(1, 0, 600, 0);
        repeat (4) step(1, 0, 700, 0);
        step(1, 0, 700, 1);
        step(0, 0, 0, 1);

        // Frame restart mid-frame.
        step(1, 0, 11, 1);
        step(1, 1, 7, 1);
        step(1, 0, 8, 1);
        step(1, 0, 9, 1);
        chk("restart_m_sof", m_sof, 1);
        step(0, 0, 0, 1);

        // Short frame then sof while a window is pending.
        step(1, 1, 1, 1);
        step(1, 0, 2, 1);
        step(1, 1, 3, 1);
        step(1, 0, 4, 1);
        step(1, 0, 5, 0);
        step(1, 1, 6, 0);
        step(1, 1, 6, 1);
        step(0, 0, 0, 1);

        // Reset mid-stream, then a frame without sof.
        step(1, 0, 50, 0);
        mid_reset();
        step(1, 0, 21, 1);
        step(1, 0, 22, 1);
        step(1, 0, 23, 1);
        chk("post_reset_valid", m_valid, 1);

        // Long frame drives the narrow counter into saturation.
        step(1, 1, 0, 1);
        for (int i = 1; i < 10; i++) step(1, 0, i * 3, 1);
        step(0, 0, 0, 1);
        chk("sat_cnt2", win_cnt2, 3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) mid_reset();
            step($urandom_range(9) < 7, $urandom_range(9) == 0,
                 int'($urandom), $urandom_range(9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
